// File: rtl/matrix_pkg.sv
// Shared matrix geometry defaults and the scanner state encoding, also used by
// the quadrant selector and the display controller.
package matrix_pkg;

  localparam int unsigned DefNCols  = 5;
  localparam int unsigned DefNRows  = 7;
  localparam int unsigned DefCoordW = 3;
  localparam int unsigned DefDwell  = 4;

  typedef enum logic [1:0] {
    StIdle,
    StOffer,
    StDwell
  } scan_state_t;

endpackage

// File: rtl/dwell_counter.sv
// Dwell-time counter: loaded on every accepted cell, counts down while the
// scanner idles, and flags zero on the last idle cycle. Saturates at zero.
module dwell_counter #(
  parameter int unsigned DWELL = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam int unsigned CntW = (DWELL > 0) ? $clog2(DWELL + 1) : 1;
  // Loading DWELL-1 makes zero coincide with the final idle cycle.
  localparam logic [CntW-1:0] LoadVal = (DWELL > 0) ? CntW'(DWELL - 1) : '0;

  logic [CntW-1:0] cnt_q;

  // Reload on transfer, otherwise count down without wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= LoadVal;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CntW'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/matrix_coord_scanner.sv
// Column-major (column, row) coordinate generator for the LED-matrix quadrant
// selector, with valid/ready handshake and a programmable dwell after each cell.
// Build option: define SCAN_SERPENTINE_EN to scan odd columns with rows descending.
module matrix_coord_scanner
  import matrix_pkg::*;
#(
  parameter int unsigned N_COLS  = DefNCols,
  parameter int unsigned N_ROWS  = DefNRows,
  parameter int unsigned COORD_W = DefCoordW,
  parameter int unsigned DWELL   = DefDwell
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               cont,
  input  logic               coord_ready,
  output logic               coord_valid,
  output logic [COORD_W-1:0] mdc,
  output logic [COORD_W-1:0] mdl,
  output logic               busy,
  output logic               frame_done
);

  if ((COORD_W < $clog2(N_COLS)) || (COORD_W < $clog2(N_ROWS))) begin : g_bad_coord_w
    $error("matrix_coord_scanner: COORD_W too narrow for N_COLS/N_ROWS");
  end

  localparam logic [COORD_W-1:0] ColMax = COORD_W'(N_COLS - 1);
  localparam logic [COORD_W-1:0] RowMax = COORD_W'(N_ROWS - 1);
  localparam logic [COORD_W-1:0] One    = COORD_W'(1);

  scan_state_t        state_q;
  logic [COORD_W-1:0] mdc_q, mdl_q;
  logic [COORD_W-1:0] next_mdc, next_mdl;
  logic               valid_q, busy_q, done_q, stop_req_q;
  logic               col_desc, col_end, is_last;
  logic               stop_eff, xfer, dwell_zero;

  // A stop seen in the same cycle as a transfer takes effect on that transfer.
  assign stop_eff = stop_req_q | stop;
  assign xfer     = (state_q == StOffer) & coord_ready;

  // Next cell in scan order; the last cell wraps to (0,0) for continuous mode.
  always_comb begin
    col_desc = 1'b0;
`ifdef SCAN_SERPENTINE_EN
    col_desc = mdc_q[0];
`endif
    col_end  = col_desc ? (mdl_q == '0) : (mdl_q == RowMax);
    is_last  = col_end && (mdc_q == ColMax);
    next_mdc = mdc_q;
    next_mdl = mdl_q;
    if (is_last) begin
      next_mdc = '0;
      next_mdl = '0;
    end else if (col_end) begin
      next_mdc = mdc_q + One;
`ifdef SCAN_SERPENTINE_EN
      // Even column ends at the top row, so the following odd column starts there.
      next_mdl = col_desc ? '0 : RowMax;
`else
      next_mdl = '0;
`endif
    end else begin
      next_mdl = col_desc ? (mdl_q - One) : (mdl_q + One);
    end
  end

  dwell_counter #(
    .DWELL(DWELL)
  ) u_dwell_counter (
    .clk  (clk),
    .rst_n(rst_n),
    .load (xfer && (DWELL != 0)),
    .dec  (state_q == StDwell),
    .zero (dwell_zero)
  );

  // Scan FSM with registered handshake and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      mdc_q      <= '0;
      mdl_q      <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      stop_req_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          stop_req_q <= 1'b0;
          if (start && !stop) begin
            state_q <= StOffer;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            mdc_q   <= '0;
            mdl_q   <= '0;
          end
        end
        StOffer: begin
          if (stop) stop_req_q <= 1'b1;
          if (coord_ready) begin
            if (is_last) done_q <= 1'b1;
            if (stop_eff || (is_last && !cont)) begin
              state_q    <= StIdle;
              valid_q    <= 1'b0;
              busy_q     <= 1'b0;
              mdc_q      <= '0;
              mdl_q      <= '0;
              stop_req_q <= 1'b0;
            end else if (DWELL == 0) begin
              mdc_q <= next_mdc;
              mdl_q <= next_mdl;
            end else begin
              state_q <= StDwell;
              valid_q <= 1'b0;
            end
          end
        end
        StDwell: begin
          if (stop) stop_req_q <= 1'b1;
          if (dwell_zero) begin
            if (stop_eff) begin
              state_q    <= StIdle;
              busy_q     <= 1'b0;
              mdc_q      <= '0;
              mdl_q      <= '0;
              stop_req_q <= 1'b0;
            end else begin
              state_q <= StOffer;
              valid_q <= 1'b1;
              mdc_q   <= next_mdc;
              mdl_q   <= next_mdl;
            end
          end
        end
        default: begin
          state_q <= StIdle;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign coord_valid = valid_q;
  assign mdc         = mdc_q;
  assign mdl         = mdl_q;
  assign busy        = busy_q;
  assign frame_done  = done_q;

endmodule

// File: tb/tb_matrix_coord_scanner.sv
// Bench for matrix_coord_scanner: DWELL=4 and DWELL=0 instances share stimulus;
// a cell-order list built from the scan rules is the reference.
module tb_matrix_coord_scanner;

  localparam int NC     = 5;
  localparam int NR     = 7;
  localparam int NCELLS = NC * NR;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, stop = 1'b0, cont = 1'b0, ready = 1'b0, sel = 1'b0;
  logic start4, start0;
  logic v4, b4, d4, v0, b0, d0;
  logic [2:0] c4, l4, c0, l0;
  logic valid_o, busy_o, done_o;
  logic [2:0] mdc_o, mdl_o;

  logic [5:0] cells [NCELLS];
  int n_chk = 0;
  int n_err = 0;
  int t = 0;

  always #5 clk = ~clk;

  assign start4  = start & ~sel;
  assign start0  = start & sel;
  assign valid_o = sel ? v0 : v4;
  assign busy_o  = sel ? b0 : b4;
  assign done_o  = sel ? d0 : d4;
  assign mdc_o   = sel ? c0 : c4;
  assign mdl_o   = sel ? l0 : l4;

  matrix_coord_scanner #(.DWELL(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .stop(stop), .cont(cont),
    .coord_ready(ready), .coord_valid(v4), .mdc(c4), .mdl(l4), .busy(b4), .frame_done(d4)
  );

  matrix_coord_scanner #(.DWELL(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .stop(stop), .cont(cont),
    .coord_ready(ready), .coord_valid(v0), .mdc(c0), .mdl(l0), .busy(b0), .frame_done(d0)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    t++;
  endtask

  task automatic start_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  function automatic int find_idx(input int c, input int r);
    for (int k = 0; k < NCELLS; k++) begin
      if (cells[k] == {3'(c), 3'(r)}) return k;
    end
    return -1;
  endfunction

  // Walk n_total transfers, checking cell order, hold stability, dwell gap,
  // busy and frame_done on every sample.
  task automatic run_cells(input int n_total, input bit rnd, input int hold_idx,
                           input int stop_idx);
    int idx = 0;
    int budget = 3000;
    int hold_left = 0;
    int t_x = 0;
    bit held = 1'b0;
    bit after = 1'b0;
    bit exp_done = 1'b0;
    int dw = sel ? 0 : 4;
    while (idx < n_total && budget > 0) begin
      budget--;
      chk("frame_done", done_o, exp_done);
      chk("busy", busy_o, 1);
      exp_done = 1'b0;
      if (valid_o) begin
        if (after) begin
          chk("dwell_gap", t - t_x, dw + 1);
          after = 1'b0;
        end
        chk("cell", {mdc_o, mdl_o}, cells[idx % NCELLS]);
        if (idx == hold_idx && !held) begin
          hold_left = 10;
          held = 1'b1;
        end
        if (hold_left > 0) begin
          ready = 1'b0;
          hold_left--;
        end else begin
          ready = rnd ? 1'($urandom_range(1, 0)) : 1'b1;
        end
        stop = (idx == stop_idx);
        if (ready) begin
          exp_done = ((idx % NCELLS) == NCELLS - 1);
          t_x = t;
          after = 1'b1;
          idx++;
        end
      end else begin
        if (hold_left > 0) chk("hold_valid", valid_o, 1);
        ready = rnd ? 1'($urandom_range(1, 0)) : 1'b1;
        stop = 1'b0;
      end
      tick();
    end
    stop = 1'b0;
    if (idx < n_total) chk("transfer_timeout", idx, n_total);
  endtask

  task automatic end_checks();
    chk("end_done", done_o, 1);
    chk("end_busy", busy_o, 0);
    chk("end_valid", valid_o, 0);
    tick();
    chk("done_pulse_width", done_o, 0);
  endtask

  initial begin
    int k;
    // Reference scan order straight from the column/row rules.
    for (int c = 0; c < NC; c++) begin
      for (int r = 0; r < NR; r++) begin
        int rr;
        rr = r;
`ifdef SCAN_SERPENTINE_EN
        if (c % 2 == 1) rr = NR - 1 - r;
`endif
        cells[c * NR + r] = {3'(c), 3'(rr)};
      end
    end

    tick();
    tick();
    chk("reset_dut4", {v4, c4, l4, b4, d4}, 0);
    chk("reset_dut0", {v0, c0, l0, b0, d0}, 0);
    rst_n = 1'b1;
    tick();

    // start together with stop is ignored in IDLE
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    chk("start_stop_busy", busy_o, 0);
    tick();
    chk("start_stop_valid", valid_o, 0);

    // Full frame, DWELL=4, ready always high
    start_frame();
    run_cells(NCELLS, 1'b0, -1, -1);
    end_checks();

    // Full frame, DWELL=0: back-to-back offers
    sel = 1'b1;
    tick();
    start_frame();
    run_cells(NCELLS, 1'b0, -1, -1);
    end_checks();
    sel = 1'b0;
    tick();

    // Backpressure: ready held low for 10 cycles on (2,3)
    start_frame();
    run_cells(NCELLS, 1'b0, find_idx(2, 3), -1);
    end_checks();

    // Random ready pattern
    start_frame();
    run_cells(NCELLS, 1'b1, -1, -1);
    end_checks();

    // Continuous mode wraps to (0,0), then stop on (1,2) of the second frame
    cont = 1'b1;
    k = NCELLS + find_idx(1, 2);
    start_frame();
    run_cells(k + 1, 1'b0, -1, k);
    cont = 1'b0;
    chk("stop_busy", busy_o, 0);
    chk("stop_no_done", done_o, 0);
    chk("stop_valid", valid_o, 0);
    tick();

    // Stop raised during dwell: no further offer, busy falls at dwell end
    start_frame();
    run_cells(6, 1'b0, -1, -1);
    stop = 1'b1;
    chk("dstop_valid1", valid_o, 0);
    tick();
    stop = 1'b0;
    chk("dstop_valid2", valid_o, 0);
    tick();
    tick();
    chk("dstop_busy_in_dwell", busy_o, 1);
    chk("dstop_valid4", valid_o, 0);
    tick();
    chk("dstop_busy_after", busy_o, 0);
    chk("dstop_valid5", valid_o, 0);
    chk("dstop_no_done", done_o, 0);
    tick();

    // Asynchronous reset mid-dwell after (3,5)
    k = find_idx(3, 5);
    start_frame();
    run_cells(k + 1, 1'b0, -1, -1);
    chk("pre_reset_busy", busy_o, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {v4, c4, l4, b4, d4}, 0);
    tick();
    chk("async_reset_no_done", d4, 0);
    rst_n = 1'b1;
    tick();
    start_frame();
    run_cells(2, 1'b0, -1, -1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
